mmio_mem_ctrl: RTL and testbench
================================

MMIO_MEM_CTRL -- requirements
Module: mmio_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width (multiple of 8).
REQ-002 SHALL have parameter RAM_DEPTH, default 256, meaning RAM size in DATA_W words (power of two).
REQ-003 SHALL have parameter N_OUT, default 2, meaning number of memory-mapped output registers.
REQ-004 SHALL have parameter OUT_W, default 16, meaning width of each output register (at most DATA_W).
REQ-005 SHALL have parameter MMIO_BASE, default 32'h0001_0000, meaning byte address of output register 0.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit, meaning a request is presented.
REQ-009 SHALL have port req_ready, output, 1 bit, meaning the request is accepted this cycle.
REQ-010 SHALL have port req_we, input, 1 bit, meaning 1 is write and 0 is read.
REQ-011 SHALL have port req_addr, input, 32 bits, meaning byte address, word aligned.
REQ-012 SHALL have port req_wdata, input, DATA_W bits, meaning write data.
REQ-013 SHALL have port req_be, input, DATA_W/8 bits, meaning byte enables for writes.
REQ-014 SHALL have port rsp_valid, output, 1 bit, meaning read data is valid (one-cycle pulse).
REQ-015 SHALL have port rsp_rdata, output, DATA_W bits, meaning read data.
REQ-016 SHALL have port data_out, output, N_OUT*OUT_W bits, meaning concatenated output registers, with register i at [i*OUT_W +: OUT_W].
REQ-017 SHALL have port err, output, 1 bit, meaning sticky error flag.

Function
REQ-018 SHALL accept a request on any rising edge where req_valid and req_ready are both 1.
REQ-019 SHALL use a two-state FSM: IDLE (req_ready=1) and RESP (req_ready=0).
REQ-020 SHALL decode RAM as byte addresses 0 to 4*RAM_DEPTH-1, with word index req_addr[log2(RAM_DEPTH)+1:2].
REQ-021 SHALL decode output register i at address MMIO_BASE+4*i, for i from 0 to N_OUT-1.
REQ-022 SHALL treat any other address, or any address with req_addr[1:0] not equal to 0, as illegal.
REQ-023 SHALL complete an accepted write at the acceptance edge, writing only bytes whose req_be bit is set, with no response and the FSM staying in IDLE.
REQ-024 SHALL truncate MMIO writes to OUT_W bits, with byte enables applied to the bytes that overlap the register.
REQ-025 SHALL, on an accepted read, move the FSM to RESP and assert rsp_valid with rsp_rdata for exactly the cycle after acceptance, then return to IDLE; read latency is 1 cycle, so back-to-back reads are accepted every second cycle.
REQ-026 SHALL return MMIO reads zero-extended from OUT_W to DATA_W.
REQ-027 SHALL ignore req_be on reads.
REQ-028 SHALL ignore illegal writes (no state change) and set err.
REQ-029 SHALL return 0 for illegal reads with normal rsp_valid timing, and set err.
REQ-030 SHALL hold err at 1 until rst.
REQ-031 SHALL hold rsp_rdata at 0 whenever rsp_valid is 0.
REQ-032 SHALL leave RAM contents undefined at power-up; rst does not clear RAM.

Reset
REQ-033 SHALL, while rst is 1 at a clock edge, set FSM=IDLE, rsp_valid=0, rsp_rdata=0, err=0 and all output registers to 0, and accept no request that cycle.
REQ-034 SHALL abort a pending read response when rst is asserted during RESP (no rsp_valid), with req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-035 SHALL place the FSM state encoding, the default MMIO_BASE and the address-region decode constants in the shared package cpu_pkg.
REQ-036 SHALL implement RAM as sub-module ram_sp: single-port, byte-enable write, registered read, parametrised by DATA_W and RAM_DEPTH.

Verification
REQ-037 SHALL be verified by: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rsp_valid one cycle after acceptance, rdata=0xDEADBEEF, err=0.
REQ-038 SHALL be verified by: write 0x11223344 to 0x20 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD.
REQ-039 SHALL be verified by: write 0x0001BEEF to MMIO_BASE+4 -> data_out[31:16]=0xBEEF, data_out[15:0] unchanged, read back gives 0x0000BEEF.
REQ-040 SHALL be verified by: write to 0x00000402 (misaligned) and read 0x00020000 (unmapped) -> no state change, read returns 0, err=1 and stays 1.
REQ-041 SHALL be verified by: req_valid held for 4 consecutive reads -> req_ready pattern 1,0,1,0, and exactly 4 rsp_valid pulses in order.
REQ-042 SHALL be verified by: rst asserted in the RESP cycle -> no rsp_valid, data_out=0, err=0, req_ready=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the MMIO/RAM request controller: FSM encoding,
// address-region tags and the default output-register base address.
package cpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM     = 2'd0,
    RGN_MMIO    = 2'd1,
    RGN_ILLEGAL = 2'd2
  } region_e;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0001_0000;
  localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Contents are not reset; the read register only updates on read accesses.
module ram_sp #(
  parameter int DATA_W    = 32,
  parameter int RAM_DEPTH = 256,
  localparam int AW       = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mmio_mem_ctrl.sv
// Request controller decoding a word-addressed RAM and a small bank of
// memory-mapped output registers; reads answer one cycle after acceptance.
//
// state   | meaning
// ST_IDLE | ready for a request; writes complete here
// ST_RESP | read response presented, no request accepted
module mmio_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          RAM_DEPTH = 256,
  parameter int          N_OUT     = 2,
  parameter int          OUT_W     = 16,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [N_OUT*OUT_W-1:0] data_out,
  output logic                   err
);

  localparam int AW = $clog2(RAM_DEPTH);

  state_e                 state;
  region_e                region;
  logic                   rsp_valid_q;
  logic                   sel_ram_q;
  logic                   err_q;
  logic [DATA_W-1:0]      rd_hold_q;
  logic [DATA_W-1:0]      ram_rdata;
  logic [DATA_W-1:0]      mmio_rdata;
  logic [N_OUT*OUT_W-1:0] data_q;
  logic [31:0]            mmio_off;
  logic [N_OUT-1:0]       mmio_hit;
  logic                   accept;
  logic                   ram_en;

  // RAM wins if a misconfigured MMIO_BASE overlaps the RAM window.
  always_comb begin
    mmio_off = req_addr - MMIO_BASE;
    mmio_hit = '0;
    for (int i = 0; i < N_OUT; i++) begin
      mmio_hit[i] = (mmio_off == 32'(WORD_BYTES * i));
    end
    if (req_addr[1:0] != 2'b00)           region = RGN_ILLEGAL;
    else if (req_addr[31:AW+2] == '0)     region = RGN_RAM;
    else if (|mmio_hit)                   region = RGN_MMIO;
    else                                  region = RGN_ILLEGAL;
  end

  always_comb begin
    mmio_rdata = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (mmio_hit[i]) mmio_rdata[OUT_W-1:0] = data_q[i*OUT_W +: OUT_W];
    end
  end

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign ram_en    = accept && (region == RGN_RAM);

  ram_sp #(
    .DATA_W    (DATA_W),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_we),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      sel_ram_q   <= 1'b0;
      rd_hold_q   <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      sel_ram_q   <= 1'b0;
      rd_hold_q   <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (region == RGN_ILLEGAL) err_q <= 1'b1;
            if (req_we) begin
              if (region == RGN_MMIO) begin
                for (int i = 0; i < N_OUT; i++) begin
                  for (int j = 0; j < OUT_W; j++) begin
                    if (mmio_hit[i] && req_be[j/8]) data_q[i*OUT_W+j] <= req_wdata[j];
                  end
                end
              end
            end else begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              sel_ram_q   <= (region == RGN_RAM);
              rd_hold_q   <= mmio_rdata;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset arriving during RESP must suppress the pending response.
  assign rsp_valid = rsp_valid_q && !rst;
  assign rsp_rdata = rsp_valid ? (sel_ram_q ? ram_rdata : rd_hold_q) : '0;
  assign data_out  = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mmio_mem_ctrl.sv
// Scoreboard bench for mmio_mem_ctrl: directed requests push expected read
// data and response cycle; a negedge monitor pops and compares responses.
module tb_mmio_mem_ctrl;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] data_out;
  logic        err;

  mmio_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .data_out  (data_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%0h, expected no response", rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_data"}, rsp_rdata, mon_e.data);
        check({mon_e.name, "_cycle"}, cyc, mon_e.at);
      end
    end else if (rst === 1'b0) begin
      check("idle_rdata_zero", rsp_rdata, 0);
    end
  end

  task automatic xact(input string name, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic [31:0] expv);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_accept: got req_ready=0 for 10 cycles, expected acceptance", name);
    end else if (!we) begin
      sb.push_back('{data: expv, at: cyc + 1, name: name});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  int nacc;

  initial begin
    @(negedge clk);
    check("ready_in_rst", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;

    // full-word write/read
    xact("w10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact("r10", 1'b0, 32'h10, 0, 4'hF, 32'hDEADBEEF);
    check("err_after_r10", err, 0);

    // byte enables; be ignored on reads
    xact("w20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    xact("w20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    xact("r20", 1'b0, 32'h20, 0, 4'h0, 32'h11BB33DD);

    // MMIO registers
    xact("wm0", 1'b1, BASE, 32'h00001234, 4'hF, 0);
    xact("wm1", 1'b1, BASE + 4, 32'h0001BEEF, 4'hF, 0);
    check("mmio1_hi", data_out[31:16], 16'hBEEF);
    check("mmio1_lo_kept", data_out[15:0], 16'h1234);
    xact("rm1", 1'b0, BASE + 4, 0, 4'hF, 32'h0000BEEF);
    xact("rm0", 1'b0, BASE, 0, 4'hF, 32'h00001234);
    xact("wm0_be", 1'b1, BASE, 32'hFFFF5600, 4'b0010, 0);
    check("mmio0_be", data_out, 32'hBEEF5634);
    xact("wm1_be_out", 1'b1, BASE + 4, 32'h00AB0000, 4'b0100, 0);
    check("mmio1_be_outside", data_out, 32'hBEEF5634);

    // RAM boundaries
    xact("w3fc", 1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, 0);
    xact("w0", 1'b1, 32'h0, 32'h01020304, 4'hF, 0);
    xact("r3fc", 1'b0, 32'h3FC, 0, 4'hF, 32'h0BADCAFE);
    check("err_legal", err, 0);

    // illegal accesses
    xact("w402", 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 0);
    check("err_misaligned", err, 1);
    xact("w400", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    xact("wm2", 1'b1, BASE + 8, 32'hFFFFFFFF, 4'hF, 0);
    xact("wm_mis", 1'b1, BASE + 2, 32'hFFFFFFFF, 4'hF, 0);
    check("illegal_no_mmio_change", data_out, 32'hBEEF5634);
    xact("r0_alias", 1'b0, 32'h0, 0, 4'hF, 32'h01020304);
    xact("r3fc_again", 1'b0, 32'h3FC, 0, 4'hF, 32'h0BADCAFE);
    xact("r_unmapped", 1'b0, 32'h0002_0000, 0, 4'hF, 32'h0);
    xact("rm2", 1'b0, BASE + 8, 0, 4'hF, 32'h0);
    check("err_sticky", err, 1);

    // back-to-back reads with req_valid held
    for (int k = 0; k < 4; k++) xact("wb2b", 1'b1, 32'h40 + 4 * k, 32'hA000_0000 + k, 4'hF, 0);
    nacc = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_be    = 4'h0;
    req_addr  = 32'h40;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready%0d", k), req_ready, (k % 2 == 0));
      if (req_ready === 1'b1 && req_valid) begin
        sb.push_back('{data: 32'hA000_0000 + nacc, at: cyc + 1, name: $sformatf("b2b%0d", nacc)});
        nacc++;
      end
      @(posedge clk);
      #1;
      if (nacc == 4) req_valid = 1'b0;
      else req_addr = 32'h40 + 4 * nacc;
    end

    // reset during RESP aborts the response
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h40;
    @(negedge clk);
    check("pre_rst_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_rsp", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_data_out", data_out, 0);
    check("post_rst_err", err, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    xact("r10_kept", 1'b0, 32'h10, 0, 4'hF, 32'hDEADBEEF);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
